// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/redirect sequencing for the D/E/M/W pipeline registers,
// with the mult/div busy FSM and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int          MULT_CYCLES = 5,
    parameter int          DIV_CYCLES  = 10,
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        eret_D,
    input  logic [31:0] epc,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  Tuse_rs_D,
    input  logic [1:0]  Tuse_rt_D,
    input  logic [4:0]  A3_E,
    input  logic [4:0]  A3_M,
    input  logic [1:0]  Tnew_E,
    input  logic [1:0]  Tnew_M,
    input  logic        md_start_E,
    input  logic        md_is_div_E,
    input  logic        md_use_D,
    output logic        pc_en,
    output logic [1:0]  npc_sel,
    output logic [31:0] exc_pc,
    output logic        d_en,
    output logic        d_reset,
    output logic        e_reset,
    output logic        e_reset_pc,
    output logic        m_reset,
    output logic        req_o,
    output logic        stall,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);
    localparam int MAXC = DIV_CYCLES > MULT_CYCLES ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1) < 4 ? 4 : $clog2(MAXC + 1);

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

    md_state_t     state, state_n;
    logic [CW-1:0] md_cnt, md_cnt_n;
    logic          hz_rs, hz_rt, hz_md;

    assign hz_rs = (rs_D != 5'd0) & (((A3_E == rs_D) & (Tnew_E > Tuse_rs_D)) |
                                     ((A3_M == rs_D) & (Tnew_M > Tuse_rs_D)));
    assign hz_rt = (rt_D != 5'd0) & (((A3_E == rt_D) & (Tnew_E > Tuse_rt_D)) |
                                     ((A3_M == rt_D) & (Tnew_M > Tuse_rt_D)));
    assign hz_md = md_use_D & (md_busy | md_start_E);
    assign stall = ~reset & ~Req & (hz_rs | hz_rt | hz_md);
    assign md_busy = (state == MD_BUSY);
    assign exc_pc = npc_sel == 2'd1 ? EXC_VECTOR : npc_sel == 2'd2 ? epc : 32'd0;

    always_comb begin
        state_n  = state;
        md_cnt_n = md_cnt;
        if (state == MD_IDLE) begin
            if (md_start_E & ~Req) begin
                state_n  = MD_BUSY;
                md_cnt_n = md_is_div_E ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end
        end else begin
            md_cnt_n = md_cnt - 1'b1;
            state_n  = md_cnt == CW'(1) ? MD_IDLE : MD_BUSY;
        end
    end

    always_comb begin
        pc_en      = 1'b1;
        d_en       = 1'b1;
        npc_sel    = 2'd0;
        d_reset    = 1'b0;
        e_reset    = 1'b0;
        e_reset_pc = 1'b0;
        m_reset    = 1'b0;
        req_o      = 1'b0;
        if (reset) begin
            pc_en      = 1'b0;
            d_en       = 1'b0;
            d_reset    = 1'b1;
            e_reset    = 1'b1;
            e_reset_pc = 1'b1;
            m_reset    = 1'b1;
        end else if (Req) begin
            npc_sel    = 2'd1;
            d_en       = 1'b0;
            d_reset    = 1'b1;
            e_reset    = 1'b1;
            e_reset_pc = 1'b1;
            m_reset    = 1'b1;
            req_o      = 1'b1;
        end else if (stall) begin
            // bubble keeps PC/BD in E so a later EPC stays correct
            pc_en   = 1'b0;
            d_en    = 1'b0;
            e_reset = 1'b1;
        end else if (eret_D) begin
            npc_sel = 2'd2;
            d_reset = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= MD_IDLE;
            md_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            state  <= state_n;
            md_cnt <= md_cnt_n;
            if (stall & ~&stall_cnt) stall_cnt <= stall_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;
    typedef struct packed {
        logic        pc_en;
        logic [1:0]  npc_sel;
        logic [31:0] exc_pc;
        logic        d_en, d_reset, e_reset, e_reset_pc, m_reset, req_o, stall, md_busy;
        logic [31:0] stall_cnt;
    } outs_t;

    localparam int K_NORM = 0, K_STALL = 1, K_REQ = 2, K_ERET = 3, K_RST = 4;

    logic        clk = 1'b0;
    logic        reset, Req, eret_D, md_start_E, md_is_div_E, md_use_D;
    logic [31:0] epc;
    logic [4:0]  rs_D, rt_D, A3_E, A3_M;
    logic [1:0]  Tuse_rs_D, Tuse_rt_D, Tnew_E, Tnew_M;
    logic        pc_en, d_en, d_reset, e_reset, e_reset_pc, m_reset, req_o, stall, md_busy;
    logic [1:0]  npc_sel;
    logic [31:0] exc_pc, stall_cnt;

    outs_t       sb[$];
    int          total = 0, bad = 0;
    logic [31:0] exp_cnt = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset), .Req(Req), .eret_D(eret_D), .epc(epc),
        .rs_D(rs_D), .rt_D(rt_D), .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D),
        .A3_E(A3_E), .A3_M(A3_M), .Tnew_E(Tnew_E), .Tnew_M(Tnew_M),
        .md_start_E(md_start_E), .md_is_div_E(md_is_div_E), .md_use_D(md_use_D),
        .pc_en(pc_en), .npc_sel(npc_sel), .exc_pc(exc_pc), .d_en(d_en), .d_reset(d_reset),
        .e_reset(e_reset), .e_reset_pc(e_reset_pc), .m_reset(m_reset), .req_o(req_o),
        .stall(stall), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    function automatic outs_t ex(int k, logic b, logic [31:0] c, logic [31:0] ep);
        outs_t o;
        o = '0;
        o.md_busy = b;
        o.stall_cnt = c;
        case (k)
            K_NORM:  begin o.pc_en = 1; o.d_en = 1; end
            K_STALL: begin o.stall = 1; o.e_reset = 1; end
            K_REQ:   begin
                o.pc_en = 1; o.npc_sel = 2'd1; o.exc_pc = 32'h0000_4180; o.req_o = 1;
                o.d_reset = 1; o.e_reset = 1; o.e_reset_pc = 1; o.m_reset = 1;
            end
            K_ERET:  begin o.pc_en = 1; o.d_en = 1; o.npc_sel = 2'd2; o.exc_pc = ep; o.d_reset = 1; end
            default: begin o.d_reset = 1; o.e_reset = 1; o.e_reset_pc = 1; o.m_reset = 1; end
        endcase
        return o;
    endfunction

    task automatic clr();
        Req = 0; eret_D = 0; epc = 0; rs_D = 0; rt_D = 0; Tuse_rs_D = 3; Tuse_rt_D = 3;
        A3_E = 0; A3_M = 0; Tnew_E = 0; Tnew_M = 0; md_start_E = 0; md_is_div_E = 0; md_use_D = 0;
    endtask

    // inputs are already driven; expectation queued now, compared mid-cycle, then advance one edge
    task automatic step(string tag, int k, logic b);
        outs_t got, e;
        sb.push_back(ex(k, b, exp_cnt, epc));
        @(negedge clk);
        got = {pc_en, npc_sel, exc_pc, d_en, d_reset, e_reset, e_reset_pc, m_reset, req_o,
               stall, md_busy, stall_cnt};
        e = sb.pop_front();
        total++;
        assert (got === e) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, e);
        end
        if (k == K_STALL) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        step("reset", K_RST, 0);
        reset = 0;
        step("normal", K_NORM, 0);
        A3_E = 1; Tnew_E = 2; rs_D = 1; Tuse_rs_D = 1;
        step("lw_use_rs", K_STALL, 0);
        Tnew_E = 1;
        step("rs_ready", K_NORM, 0);
        clr(); A3_E = 0; A3_M = 0; Tnew_E = 2; rs_D = 0; Tuse_rs_D = 0;
        step("rs_zero", K_NORM, 0);
        clr(); A3_M = 5; Tnew_M = 1; rt_D = 5; Tuse_rt_D = 0;
        step("rt_m_hazard", K_STALL, 0);
        Tuse_rt_D = 1;
        step("rt_m_ready", K_NORM, 0);
        clr(); md_start_E = 1; md_use_D = 1;
        step("mult_issue_mflo", K_STALL, 0);
        md_start_E = 0;
        for (int i = 1; i <= 5; i++) step($sformatf("mult_busy%0d", i), K_STALL, 1);
        step("mult_done", K_NORM, 0);
        if (exp_cnt != 32'd8) begin
            total++;
            bad++;
            $error("FAIL exp_cnt_track got=%0d exp=8", exp_cnt);
        end
        clr(); md_start_E = 1; md_is_div_E = 1;
        step("div_issue", K_NORM, 0);
        clr();
        for (int i = 1; i <= 10; i++) begin
            Req = (i == 3 || i == 5);
            md_use_D = (i == 5);
            step($sformatf("div_busy%0d", i), (i == 3 || i == 5) ? K_REQ : K_NORM, 1);
        end
        clr();
        step("div_done", K_NORM, 0);
        Req = 1; md_start_E = 1; md_is_div_E = 1;
        step("req_blocks_issue", K_REQ, 0);
        clr();
        step("no_busy_after_req", K_NORM, 0);
        eret_D = 1; epc = 32'h0000_3010;
        step("eret", K_ERET, 0);
        A3_E = 7; Tnew_E = 3; rs_D = 7; Tuse_rs_D = 2;
        step("eret_stalled", K_STALL, 0);
        clr(); md_start_E = 1; md_is_div_E = 1;
        step("div_issue2", K_NORM, 0);
        clr();
        step("div2_busy1", K_NORM, 1);
        reset = 1; md_use_D = 1;
        step("reset_mid_div", K_RST, 1);
        reset = 0; clr();
        exp_cnt = 0;
        step("after_reset", K_NORM, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
